// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: one Feistel round per clock and 16 rounds per block.
// Valid/ready on both sides; the result is held until the consumer accepts it.
module des_decrypt_core (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [63:0] i_cipher,
  input  logic [63:0] i_key,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [63:0] o_plain,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // One nibble per entry, row-major (row = outer bits, col = inner four bits), entry 0 in the MSBs.
  localparam logic [255:0] S_T [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int unsigned j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [47:0] e_perm(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int unsigned j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[5'(j)])];
    return y;
  endfunction

  function automatic logic [3:0] sbox(input logic [255:0] tbl, input logic [5:0] b);
    logic [255:0] sh;
    sh = tbl << {b[5], b[0], b[4:1], 2'b00};
    return sh[255:252];
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    x = e_perm(r) ^ k;
    s = '0;
    for (int unsigned n = 0; n < 8; n++)
      s[5'(31 - 4 * n) -: 4] = sbox(S_T[3'(n)], x[6'(47 - 6 * n) -: 6]);
    return p_perm(s);
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] sh);
    case (sh)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  state_t      r_state, w_state_next;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d;
  logic [3:0]  r_cnt;
  logic [63:0] r_plain;
  logic        r_valid;

  logic [1:0]  w_shift;
  logic [27:0] w_c_rot, w_d_rot;
  logic [47:0] w_subkey;
  logic [31:0] w_r_next;
  logic [63:0] w_ip;
  logic [55:0] w_cd;

  // Subkeys are generated in reverse: PC1 output equals C16/D16, then each round rotates right.
  always_comb begin
    w_shift = 2'd2;
    if (r_cnt == 4'd0)
      w_shift = 2'd0;
    else if (r_cnt == 4'd1 || r_cnt == 4'd8 || r_cnt == 4'd15)
      w_shift = 2'd1;
    w_c_rot  = rotr28(r_c, w_shift);
    w_d_rot  = rotr28(r_d, w_shift);
    w_subkey = pc2_perm({w_c_rot, w_d_rot});
    w_r_next = r_l ^ f_func(r_r, w_subkey);
    w_ip     = ip_perm(i_cipher);
    w_cd     = pc1_perm(i_key);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_valid) w_state_next = ROUND;
      ROUND:   if (r_cnt == 4'd15) w_state_next = DONE;
      DONE:    if (i_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_l     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_plain <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_valid) begin
          r_l   <= w_ip[63:32];
          r_r   <= w_ip[31:0];
          r_c   <= w_cd[55:28];
          r_d   <= w_cd[27:0];
          r_cnt <= '0;
        end
        ROUND: begin
          r_l   <= r_r;
          r_r   <= w_r_next;
          r_c   <= w_c_rot;
          r_d   <= w_d_rot;
          r_cnt <= r_cnt + 4'd1;
          // Final swap: preoutput is {R16, L16} where L16 is the current R.
          if (r_cnt == 4'd15) begin
            r_plain <= fp_perm({w_r_next, r_r});
            r_valid <= 1'b1;
          end
        end
        DONE: if (i_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_busy  = (r_state != IDLE);
  assign o_valid = r_valid;
  assign o_plain = r_plain;

endmodule
